extractor: RTL and testbench

EXTRACTOR -- requirements
Module: extractor

---
 rtl/extractor.sv | 64 ++++++
 tb/tb_extractor.sv | 103 ++++++++++
 2 files changed

// File: rtl/extractor.sv
// RV32 immediate extractor: combinational format decode, one registered output stage.
// Optional CSR uimm (IMM_Z) decode is enabled by defining EXTRACTOR_IMM_Z_EN.
package riscv_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } immscr_e;
endpackage

module extractor #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic [2:0]      imm_src,
  input  logic            in_valid,
  output logic [XLEN-1:0] imm_ext,
  output logic            out_valid
);

  logic [XLEN-1:0] decoded;
  logic            unused_opcode;

  // Opcode bits never contribute to any immediate format.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    decoded = '0;
    case (imm_src)
      riscv_pkg::IMM_I: decoded = {{20{instr[31]}}, instr[31:20]};
      riscv_pkg::IMM_S: decoded = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      riscv_pkg::IMM_B: decoded = {{19{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0};
      riscv_pkg::IMM_U: decoded = {instr[31:12], 12'b0};
      riscv_pkg::IMM_J: decoded = {{11{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0};
`ifdef EXTRACTOR_IMM_Z_EN
      riscv_pkg::IMM_Z: decoded = {27'b0, instr[19:15]};
`else
      riscv_pkg::IMM_Z: decoded = '0;
`endif
      default:          decoded = '0;
    endcase
  end

  // Reset wins over in_valid, so an input on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_ext   <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      imm_ext   <= decoded;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_extractor.sv
// Directed self-checking bench for extractor; expectations hand-computed per vector.
module tb_extractor;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        in_valid;
  logic [31:0] imm_ext;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  extractor #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .imm_src  (imm_src),
    .in_valid (in_valid),
    .imm_ext  (imm_ext),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic [31:0] i, input logic [2:0] s);
    rst_n    = r;
    in_valid = v;
    instr    = i;
    imm_src  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0;
    step(1'b0, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b0, 32'h0, 3'd0);
    chk("reset_imm", imm_ext, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);

    step(1'b1, 1'b1, 32'hFFA9A383, 3'd0);
    chk("imm_i_neg", imm_ext, 32'hFFFFFFFA);
    chk("imm_i_valid", {31'b0, out_valid}, 32'd1);

    step(1'b1, 1'b1, 32'h01429BA3, 3'd1);
    chk("imm_s", imm_ext, 32'h00000017);
    step(1'b1, 1'b1, 32'hCB9C1263, 3'd2);
    chk("imm_b", imm_ext, 32'hFFFFF4A4);
    chk("imm_b_valid", {31'b0, out_valid}, 32'd1);

    step(1'b1, 1'b1, 32'h8CDEFAB7, 3'd3);
    chk("imm_u", imm_ext, 32'h8CDEF000);
    step(1'b1, 1'b1, 32'h7F8A60EF, 3'd4);
    chk("imm_j_b2b", imm_ext, 32'h000A67F8);
    chk("imm_j_valid", {31'b0, out_valid}, 32'd1);

    // idle cycle with different instr: value must hold, valid drops
    step(1'b1, 1'b0, 32'hFFFFFFFF, 3'd0);
    chk("hold_imm", imm_ext, 32'h000A67F8);
    chk("hold_valid", {31'b0, out_valid}, 32'd0);

    step(1'b1, 1'b1, 32'h7FF00013, 3'd0);
    chk("imm_i_pos", imm_ext, 32'h000007FF);

    step(1'b0, 1'b1, 32'hFFA9A383, 3'd0);
    chk("rst_over_valid_imm", imm_ext, 32'h0);
    chk("rst_over_valid_v", {31'b0, out_valid}, 32'd0);

    step(1'b1, 1'b1, 32'h01429BA3, 3'd1);
    chk("post_rst_imm", imm_ext, 32'h00000017);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);

    step(1'b1, 1'b1, 32'hFFFFFFFF, 3'd6);
    chk("reserved6", imm_ext, 32'h0);
    step(1'b1, 1'b1, 32'h01429BA3, 3'd1);
    step(1'b1, 1'b1, 32'hFFFFFFFF, 3'd7);
    chk("reserved7", imm_ext, 32'h0);
    chk("reserved7_valid", {31'b0, out_valid}, 32'd1);

    step(1'b1, 1'b1, 32'h000F8073, 3'd5);
`ifdef EXTRACTOR_IMM_Z_EN
    chk("imm_z_en", imm_ext, 32'h0000001F);
`else
    chk("imm_z_dis", imm_ext, 32'h0);
`endif

    step(1'b1, 1'b0, 32'h0, 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
